// File: rtl/optical_flow_mac_pkg.sv
// Shared constants and stage-payload type for the optical-flow MAC pipeline.
// The optional saturating mode is enabled with OPTICAL_FLOW_MAC_SAT_EN.
package optical_flow_mac_pkg;

  localparam int DEF_A_WIDTH       = 18;
  localparam int DEF_B_WIDTH       = 18;
  localparam int DEF_P_WIDTH       = 48;
  localparam int DEF_NUM_STAGE     = 4;
  localparam int MIN_NUM_STAGE     = 3;
  localparam int OPERAND_MAX_WIDTH = 32;

  // Operands are held sign-extended to the container width; narrower
  // configurations only ever read the low bits back through a size cast.
  typedef struct packed {
    logic signed [OPERAND_MAX_WIDTH-1:0] a;
    logic signed [OPERAND_MAX_WIDTH-1:0] b;
    logic                                first;
    logic                                last;
    logic                                valid;
  } mac_beat_t;

  // Number of pure delay registers between the product and accumulate stages.
  function automatic int delay_depth(input int num_stage);
    return num_stage - MIN_NUM_STAGE;
  endfunction

endpackage

// File: rtl/optical_flow_mac_delay.sv
// Parametrised stall-able delay line used between the product and accumulate
// stages of the optical-flow MAC pipeline (OPTICAL_FLOW_MAC_SAT_EN unaffected).
module optical_flow_mac_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift register that moves only when the whole pipeline advances.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          pipe_r[i] <= '0;
        end
      end else if (advance) begin
        pipe_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_r[i] <= pipe_r[i-1];
        end
      end
    end

    assign dout = pipe_r[DEPTH-1];
  end

endmodule

// File: rtl/optical_flow_mac_pipe.sv
// Grouped signed multiply-accumulate pipeline with a valid/ready result port.
// Define OPTICAL_FLOW_MAC_SAT_EN for clamping accumulation and the out_sat flag.
module optical_flow_mac_pipe
  import optical_flow_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int NUM_STAGE = DEF_NUM_STAGE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [A_WIDTH-1:0] in_a,
  input  logic signed [B_WIDTH-1:0] in_b,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [P_WIDTH-1:0] out_p,
  output logic                      out_sat
);

  localparam int PROD_W    = A_WIDTH + B_WIDTH;
  localparam int PAY_W     = PROD_W + 3;
  localparam int DLY_DEPTH = delay_depth(NUM_STAGE);

  if (P_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_p_width
    $error("optical_flow_mac_pipe: P_WIDTH must be at least A_WIDTH+B_WIDTH");
  end
  if (NUM_STAGE < MIN_NUM_STAGE) begin : g_bad_num_stage
    $error("optical_flow_mac_pipe: NUM_STAGE must be at least 3");
  end
  if (A_WIDTH > OPERAND_MAX_WIDTH || B_WIDTH > OPERAND_MAX_WIDTH) begin : g_bad_operand
    $error("optical_flow_mac_pipe: operand width exceeds OPERAND_MAX_WIDTH");
  end

  logic                      advance_s;
  mac_beat_t                 s1_d_s;
  mac_beat_t                 s1_r;
  logic signed [PROD_W-1:0]  a_ext_s;
  logic signed [PROD_W-1:0]  b_ext_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic        [PAY_W-1:0]   s2_pay_r;
  logic        [PAY_W-1:0]   fin_pay_s;
  logic signed [PROD_W-1:0]  fin_prod_s;
  logic                      fin_first_s;
  logic                      fin_last_s;
  logic                      fin_valid_s;
  logic signed [P_WIDTH-1:0] prod_ext_s;
  logic signed [P_WIDTH-1:0] base_s;
  logic signed [P_WIDTH-1:0] acc_next_s;
  logic signed [P_WIDTH-1:0] acc_r;
  logic signed [P_WIDTH-1:0] out_p_r;
  logic                      out_valid_r;

  // A held result freezes every stage so no bubble or beat is ever dropped.
  assign advance_s = !out_valid_r || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign out_p     = out_p_r;

  // Stage 1 input payload, operands sign-extended into the shared struct.
  always_comb begin
    s1_d_s       = '0;
    s1_d_s.a     = OPERAND_MAX_WIDTH'(in_a);
    s1_d_s.b     = OPERAND_MAX_WIDTH'(in_b);
    s1_d_s.first = in_first;
    s1_d_s.last  = in_last;
    s1_d_s.valid = in_valid;
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= '0;
    end else if (advance_s) begin
      s1_r <= s1_d_s;
    end
  end

  assign a_ext_s = PROD_W'(s1_r.a);
  assign b_ext_s = PROD_W'(s1_r.b);
  assign prod_s  = a_ext_s * b_ext_s;

  // Stage 2 register: full-precision product plus group markers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_pay_r <= '0;
    end else if (advance_s) begin
      s2_pay_r <= {prod_s, s1_r.first, s1_r.last, s1_r.valid};
    end
  end

  optical_flow_mac_delay #(
    .WIDTH (PAY_W),
    .DEPTH (DLY_DEPTH)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (advance_s),
    .din     (s2_pay_r),
    .dout    (fin_pay_s)
  );

  assign {fin_prod_s, fin_first_s, fin_last_s, fin_valid_s} = fin_pay_s;
  assign prod_ext_s = P_WIDTH'(fin_prod_s);
  // A group start ignores whatever partial sum is still open.
  assign base_s     = fin_first_s ? '0 : acc_r;

`ifdef OPTICAL_FLOW_MAC_SAT_EN
  localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic signed [P_WIDTH:0] sum_wide_s;
  logic                    sat_hit_s;
  logic                    grp_sat_next_s;
  logic                    grp_sat_r;
  logic                    out_sat_r;

  // One guard bit exposes overflow; clamp towards the overflowed direction.
  always_comb begin
    sum_wide_s = {base_s[P_WIDTH-1], base_s} + {prod_ext_s[P_WIDTH-1], prod_ext_s};
    if (sum_wide_s[P_WIDTH] != sum_wide_s[P_WIDTH-1]) begin
      sat_hit_s  = 1'b1;
      acc_next_s = sum_wide_s[P_WIDTH] ? P_MIN : P_MAX;
    end else begin
      sat_hit_s  = 1'b0;
      acc_next_s = sum_wide_s[P_WIDTH-1:0];
    end
    grp_sat_next_s = (fin_first_s ? 1'b0 : grp_sat_r) | sat_hit_s;
  end

  // Sticky per-group clamp flag, published alongside the group result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grp_sat_r <= 1'b0;
      out_sat_r <= 1'b0;
    end else if (advance_s && fin_valid_s) begin
      if (fin_last_s) begin
        grp_sat_r <= 1'b0;
        out_sat_r <= grp_sat_next_s;
      end else begin
        grp_sat_r <= grp_sat_next_s;
      end
    end
  end

  assign out_sat = out_sat_r;
`else
  // Plain two's-complement accumulation wraps modulo 2^P_WIDTH.
  always_comb begin
    acc_next_s = base_s + prod_ext_s;
  end

  assign out_sat = 1'b0;
`endif

  // Accumulator and result register; a closing beat empties acc for the next group.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r       <= '0;
      out_p_r     <= '0;
      out_valid_r <= 1'b0;
    end else if (advance_s) begin
      if (fin_valid_s && fin_last_s) begin
        out_p_r     <= acc_next_s;
        out_valid_r <= 1'b1;
        acc_r       <= '0;
      end else if (fin_valid_s) begin
        acc_r       <= acc_next_s;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_optical_flow_mac_pipe.sv
// Self-checking bench for optical_flow_mac_pipe with a group-level reference model.
// Expectations follow OPTICAL_FLOW_MAC_SAT_EN when the bench is built with it.
module tb_optical_flow_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 36;
  localparam int NS = 4;
  localparam longint PMAX = (64'sd1 <<< (PW-1)) - 64'sd1;
  localparam longint PMIN = -(64'sd1 <<< (PW-1));

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] in_a;
  logic signed [BW-1:0] in_b;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] out_p;
  logic                 out_sat;

  typedef struct {
    longint p;
    bit     sat;
  } res_t;

  res_t   obs_q[$];
  res_t   exp_q[$];
  longint m_acc  = 0;
  bit     m_sat  = 1'b0;
  int     errors = 0;
  int     checks = 0;

  optical_flow_mac_pipe #(
    .A_WIDTH   (AW),
    .B_WIDTH   (BW),
    .P_WIDTH   (PW),
    .NUM_STAGE (NS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

`ifndef OPTICAL_FLOW_MAC_SAT_EN
  function automatic longint wrap_p(input longint v);
    longint m;
    m = v & ((64'sd1 <<< PW) - 64'sd1);
    if (m > PMAX) m = m - (64'sd1 <<< PW);
    return m;
  endfunction
`endif

  // Reference model: one accepted beat applied to the open group.
  task automatic model_beat(input longint a, input longint b, input bit first, input bit last);
    longint prod;
    longint s;
    prod = a * b;
    if (first) begin
      m_acc = prod;
      m_sat = 1'b0;
    end else begin
      s = m_acc + prod;
`ifdef OPTICAL_FLOW_MAC_SAT_EN
      if (s > PMAX) begin
        s = PMAX;
        m_sat = 1'b1;
      end else if (s < PMIN) begin
        s = PMIN;
        m_sat = 1'b1;
      end
`else
      s = wrap_p(s);
`endif
      m_acc = s;
    end
    if (last) begin
      exp_q.push_back('{p: m_acc, sat: m_sat});
      m_acc = 0;
      m_sat = 1'b0;
    end
  endtask

  // One clock cycle from a falling edge to the next; records handshakes.
  task automatic tick(output bit accepted);
    res_t r;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      r.p   = longint'(out_p);
      r.sat = out_sat;
      obs_q.push_back(r);
    end
    if (accepted) model_beat(longint'(in_a), longint'(in_b), in_first, in_last);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic compare_queues(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].p !== exp_q[i].p || obs_q[i].sat !== exp_q[i].sat) begin
        errors++;
        $display("FAIL %s[%0d]: got p=%0d sat=%0d, expected p=%0d sat=%0d",
                 name, i, obs_q[i].p, obs_q[i].sat, exp_q[i].p, exp_q[i].sat);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
    #2;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    if (out_p !== '0) begin errors++; $display("FAIL reset_out_p: got %0d, expected 0", out_p); end
    if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b, expected 0", out_sat); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_latency();
    bit acc;
    int lat;
    int edges;
    in_valid = 1'b1; in_a = 18'sd3; in_b = -18'sd5; in_first = 1'b1; in_last = 1'b1;
    out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    lat = 0;
    edges = 1;
    for (int t = 0; t < 10; t++) begin
      if (out_valid && lat == 0) lat = edges;
      tick(acc);
      edges++;
    end
    checks += 3;
    if (lat != NS) begin errors++; $display("FAIL single_latency: got %0d cycles, expected %0d", lat, NS); end
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d results, expected 1", obs_q.size());
    end else if (obs_q[0].p !== -64'sd15) begin
      errors++; $display("FAIL single_value: got %0d, expected -15", obs_q[0].p);
    end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear: out_valid got %b, expected 0", out_valid); end
    compare_queues("single");
  endtask

  task automatic test_group();
    bit acc;
    int av[4] = '{2, 4, -1, 10};
    int bv[4] = '{3, 5, 6, 10};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = AW'(av[i]); in_b = BW'(bv[i]);
      in_first = (i == 0); in_last = (i == 3);
      tick(acc);
    end
    drain(8);
    checks += 2;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL group_count: got %0d results, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0 && obs_q[0].p !== 64'sd120) begin
      errors++; $display("FAIL group_value: got %0d, expected 120", obs_q[0].p);
    end
    compare_queues("group");
  endtask

  task automatic test_back_to_back_stall();
    bit acc;
    bit held;
    int stall_cycles;
    logic signed [PW-1:0] held_p;
    held = 1'b0;
    stall_cycles = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    in_a = AW'($urandom); in_b = BW'($urandom);
    for (int c = 0; c < 12; c++) begin
      tick(acc);
      if (acc) begin
        in_a = AW'($urandom);
        in_b = BW'($urandom);
      end
      if (out_valid) begin
        stall_cycles++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready); end
        if (!held) begin
          held = 1'b1;
          held_p = out_p;
        end else begin
          checks++;
          if (out_p !== held_p) begin errors++; $display("FAIL stall_hold: got %0d, expected %0d", out_p, held_p); end
        end
      end
    end
    checks++;
    if (stall_cycles < 5) begin errors++; $display("FAIL stall_len: got %0d stalled cycles, expected at least 5", stall_cycles); end
    drain(12);
    compare_queues("stall");
  endtask

  task automatic test_random_groups();
    bit acc;
    int len;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        acc = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          out_ready = ($urandom_range(0, 3) != 0);
          tick(acc);
        end
        in_valid = 1'b1;
        in_a = AW'($urandom);
        in_b = BW'($urandom);
        in_first = (k == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
        in_last = (k == len - 1);
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick(acc);
        end
        checks++;
        if (!acc) begin errors++; $display("FAIL random_accept_timeout: group %0d beat %0d never accepted", g, k); end
      end
    end
    drain(12);
    compare_queues("random");
  endtask

  task automatic test_reset_mid_group();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = AW'(100 + i); in_b = BW'(-3); in_first = (i == 0); in_last = 1'b0;
      tick(acc);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, expected 0", out_valid); end
    #1;
    reset_n = 1'b1;
    m_acc = 0; m_sat = 1'b0;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_a = 18'sd7; in_b = 18'sd7; in_first = 1'b0; in_last = 1'b1;
    tick(acc);
    drain(8);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].p !== 64'sd49) begin
      errors++;
      $display("FAIL midreset_value: got %0d results, first p=%0d, expected one result p=49",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].p : 64'sd0);
    end
    compare_queues("midreset");
  endtask

  task automatic test_saturation();
    bit acc;
    longint exp_p;
    bit exp_sat;
`ifdef OPTICAL_FLOW_MAC_SAT_EN
    exp_p = (64'sd1 <<< 35) - 64'sd1;
    exp_sat = 1'b1;
`else
    exp_p = -(64'sd1 <<< 34);
    exp_sat = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = -18'sd131072; in_b = -18'sd131072;
      in_first = (i == 0); in_last = (i == 2);
      tick(acc);
    end
    in_valid = 1'b1; in_a = 18'sd1; in_b = 18'sd1; in_first = 1'b1; in_last = 1'b1;
    tick(acc);
    drain(8);
    checks += 2;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL sat_count: got %0d results, expected 2", obs_q.size());
    end else begin
      if (obs_q[0].p !== exp_p || obs_q[0].sat !== exp_sat) begin
        errors++;
        $display("FAIL sat_group: got p=%0d sat=%0d, expected p=%0d sat=%0d", obs_q[0].p, obs_q[0].sat, exp_p, exp_sat);
      end
      if (obs_q[1].p !== 64'sd1 || obs_q[1].sat !== 1'b0) begin
        errors++;
        $display("FAIL sat_next: got p=%0d sat=%0d, expected p=1 sat=0", obs_q[1].p, obs_q[1].sat);
      end
    end
    compare_queues("sat");
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_group();
    test_back_to_back_stall();
    test_random_groups();
    test_reset_mid_group();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
